nlc_horner_mc: RTL and testbench
================================

Name: nlc_horner_mc

Overview:
- Multi-channel ADC non-linearity correction engine. Generalises the 4-section, 10th-order, 1-channel NLC.
- Parametrised polynomial order, channel count and fixed-point widths.
- Coefficients, negative means and reciprocal stdevs live in an internal register bank written through a config port, not on a wide port list.
- Input FIFO plus valid/ready output backpressure. Sits between the ADC sample mux and the downstream decimator.

Parameters:
- NCH, 4: number of channels; each channel has its own coefficient bank.
- ORDER, 10: polynomial order (>=1).
- XW, 21: signed ADC sample / corrected output width.
- CW, 48: signed coefficient and datapath width.
- CFRAC, 24: fraction bits of every CW-bit quantity (Q(CW-CFRAC).CFRAC).
- FIFO_DEPTH, 4: input FIFO entries (power of 2).
- CHW, 2: channel-id width, max(1, clog2(NCH)).
- AW, derived: config address width, clog2(NCH*4*(ORDER+3)).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- srdyi  in  1  input sample valid
- drdyi  out  1  input ready (FIFO not full)
- x_adc  in  XW  signed raw ADC sample
- ch_in  in  CHW  channel of x_adc
- srdyo  out  1  output valid
- drdyo  in  1  downstream ready
- x_lin  out  XW  signed corrected sample
- ch_out  out  CHW  channel of x_lin
- section_limit  in  XW-1  unsigned |x| separating inner/outer sections
- cfg_we  in  1  config write strobe
- cfg_addr  in  AW  ((ch*4+sec)*(ORDER+3)+k); k=0..ORDER coeff c_k, k=ORDER+1 neg_mean, k=ORDER+2 recip_stdev; sec 0..3 = sections 1..4
- cfg_wdata  in  CW  signed Q value
- cfg_err  out  1  one-cycle pulse: write rejected
- busy  out  1  FIFO non-empty or engine not IDLE

Behaviour:
Reset:
- While reset=0, asynchronously: FIFO empty, state IDLE, srdyo=0, x_lin=0, ch_out=0, cfg_err=0, busy=0, all bank entries 0.
- Reset mid-computation discards the in-flight sample and all queued samples.
- After release, drdyi=1.

Input:
- drdyi = !fifo_full (combinational).
- A push happens on any edge with srdyi&drdyi; it stores {ch_in, x_adc}.
- Push and pop on the same edge are both honoured; the count is unchanged.
- srdyi while full is dropped, with no side effect.

Config:
- A write takes effect only when busy=0 at the edge.
- cfg_we with busy=1, or with cfg_addr >= NCH*4*(ORDER+3), is ignored and cfg_err pulses for 1 cycle.

Section select (on the latched x):
- x>0, |x|>limit: sec 4.
- x>0, |x|<=limit: sec 3.
- x<=0, |x|<=limit: sec 2.
- x<=0, |x|>limit: sec 1.
- x=0 selects sec 2.
- |x| is computed at XW bits; -2^(XW-1) has magnitude 2^(XW-1).

FSM states:
- IDLE: if FIFO non-empty, pop; latch x, ch, section -> NORM.
- NORM: t = sat_CW((((x<<<CFRAC)+neg_mean)*recip) >>> CFRAC); acc = c_ORDER; k = ORDER-1 -> MAC.
- MAC: acc = sat_CW(((acc*t)>>>CFRAC) + c_k). Full-precision 2*CW product; the shift truncates toward -inf.
  - k>0: k-1, stay in MAC.
  - k=0: x_lin = sat_XW(acc>>>CFRAC), ch_out = ch, srdyo=1 -> OUT.
- OUT: hold x_lin/ch_out/srdyo stable while drdyo=0. On an edge with drdyo=1, srdyo=0 -> IDLE.

Saturation: sat_N clamps to [-2^(N-1), 2^(N-1)-1].

Latency and throughput:
- Sample pushed at edge E0 into an empty FIFO with an idle engine: srdyo rises after edge E0+ORDER+2 (12 for ORDER=10).
- Steady-state period is ORDER+3 cycles per sample with drdyo=1.
- Samples are processed in FIFO (arrival) order regardless of channel.

Test Plan:
- Identity: ch0, all four sections programmed c1=1.0 (0x000001000000), others 0, neg_mean=0, recip=1.0; push x=100, then x=-100 -> x_lin=100 then -100, ch_out=0, first srdyo exactly 12 cycles after push.
- Section boundaries: limit=1000; c0 = 1.0/2.0/3.0/4.0 for sec 1..4, other coeffs 0; push x=-1001, -1000, 0, 1000, 1001 -> outputs 1, 2, 2, 3, 4.
- Saturation: c0=0x7FFFFFFFFFFF -> x_lin=1048575. c0=0x800000000000 -> x_lin=-1048576. Overflowing MAC (c10=c9=2^23-1.0, t large) clamps without wraparound.
- Normalisation + channels: ch2 sec3 neg_mean=-50.0, recip=0.5, c1=1.0, others 0; push x=150 on ch2 -> 50, ch_out=2. Same x on ch0 (unprogrammed) -> 0.
- Backpressure/FIFO: drdyo=0; push 6 back-to-back samples -> first waits in OUT with srdyo held, next 4 fill the FIFO, drdyi=0 while the 6th is offered, and it is not stored. Release drdyo -> 5 outputs in order, drdyi returns to 1.
- Config lock + reset: cfg_we while busy -> cfg_err pulse, bank unchanged. Assert reset mid-MAC -> srdyo=0, x_lin=0, busy=0 immediately, and no output emitted after release.

Source files
------------

// File: rtl/nlc_horner_mc_if.sv
// Sample-in / sample-out valid/ready bundle for nlc_horner_mc.
// slave = correction engine side, master = ADC mux / decimator side.
interface nlc_horner_mc_if #(
  parameter int XW  = 21,
  parameter int CHW = 2
);
  logic                  srdyi;
  logic                  drdyi;
  logic signed [XW-1:0]  x_adc;
  logic [CHW-1:0]        ch_in;
  logic                  srdyo;
  logic                  drdyo;
  logic signed [XW-1:0]  x_lin;
  logic [CHW-1:0]        ch_out;

  modport slave (
    input  srdyi, x_adc, ch_in, drdyo,
    output drdyi, srdyo, x_lin, ch_out
  );

  modport master (
    output srdyi, x_adc, ch_in, drdyo,
    input  drdyi, srdyo, x_lin, ch_out
  );
endinterface

// File: rtl/nlc_horner_mc.sv
// Multi-channel ADC non-linearity correction: 4-section Horner polynomial
// per channel, coefficient bank behind a config port, input FIFO, backpressure.
module nlc_horner_mc #(
  parameter int NCH        = 4,
  parameter int ORDER      = 10,
  parameter int XW         = 21,
  parameter int CW         = 48,
  parameter int CFRAC      = 24,
  parameter int FIFO_DEPTH = 4,
  parameter int CHW        = 2,
  parameter int AW         = $clog2(NCH*4*(ORDER+3))
) (
  input  logic                 clk,
  input  logic                 reset,
  nlc_horner_mc_if.slave       s,
  input  logic [XW-2:0]        section_limit,
  input  logic                 cfg_we,
  input  logic [AW-1:0]        cfg_addr,
  input  logic signed [CW-1:0] cfg_wdata,
  output logic                 cfg_err,
  output logic                 busy
);
  localparam int NK   = ORDER + 3;
  localparam int NENT = NCH * 4 * NK;
  localparam int PW   = 2 * CW + 4;
  localparam int KW   = (ORDER > 1) ? $clog2(ORDER) : 1;
  localparam int PTRW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int SW   = CHW + XW;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_NORM = 2'd1;
  localparam logic [1:0] S_MAC  = 2'd2;
  localparam logic [1:0] S_OUT  = 2'd3;

  localparam logic signed [PW-1:0] CMAX =
    {{(PW-CW+1){1'b0}}, {(CW-1){1'b1}}};
  localparam logic signed [PW-1:0] CMIN =
    {{(PW-CW+1){1'b1}}, {(CW-1){1'b0}}};
  localparam logic signed [PW-1:0] XMAX =
    {{(PW-XW+1){1'b0}}, {(XW-1){1'b1}}};
  localparam logic signed [PW-1:0] XMIN =
    {{(PW-XW+1){1'b1}}, {(XW-1){1'b0}}};

  function automatic logic signed [PW-1:0] sx(
    input logic signed [CW-1:0] v
  );
    return {{(PW-CW){v[CW-1]}}, v};
  endfunction

  function automatic logic signed [CW-1:0] sat_cw(
    input logic signed [PW-1:0] v
  );
    if (v > CMAX) return CMAX[CW-1:0];
    if (v < CMIN) return CMIN[CW-1:0];
    return v[CW-1:0];
  endfunction

  function automatic logic signed [XW-1:0] sat_xw(
    input logic signed [PW-1:0] v
  );
    if (v > XMAX) return XMAX[XW-1:0];
    if (v < XMIN) return XMIN[XW-1:0];
    return v[XW-1:0];
  endfunction

  logic [1:0]           state_q, state_d;
  logic [KW-1:0]        k_q, k_d;
  logic signed [XW-1:0] x_q, x_d;
  logic [CHW-1:0]       ch_q, ch_d;
  logic [1:0]           sec_q, sec_d;
  logic signed [CW-1:0] t_q, t_d;
  logic signed [CW-1:0] acc_q, acc_d;
  logic signed [XW-1:0] x_lin_q, x_lin_d;
  logic [CHW-1:0]       ch_out_q, ch_out_d;
  logic                 srdyo_q, srdyo_d;
  logic                 cfg_err_q, cfg_err_d;
  logic [SW-1:0]        mem_q [FIFO_DEPTH];
  logic [SW-1:0]        mem_d [FIFO_DEPTH];
  logic [PTRW-1:0]      wp_q, wp_d, rp_q, rp_d;
  logic [PTRW:0]        cnt_q, cnt_d;
  logic signed [CW-1:0] bank_q [NENT];
  logic signed [CW-1:0] bank_d [NENT];

  logic full, empty, push, pop, cfg_ok;
  logic [SW-1:0]        head;
  logic signed [XW-1:0] hx;
  logic [CHW-1:0]       hch;
  logic [XW-1:0]        hmag;
  logic                 hpos, hbig;
  logic [1:0]           hsec;

  assign full  = cnt_q == (PTRW+1)'(FIFO_DEPTH);
  assign empty = cnt_q == '0;
  assign push  = s.srdyi && !full;
  assign pop   = (state_q == S_IDLE) && !empty;
  assign busy  = !empty || (state_q != S_IDLE);

  assign head = mem_q[rp_q];
  assign hx   = head[XW-1:0];
  assign hch  = head[SW-1:XW];
  // XW-bit negate keeps the most negative sample's magnitude as 2^(XW-1)
  assign hmag = hx[XW-1] ? (~hx + 1'b1) : hx;
  assign hbig = hmag > {1'b0, section_limit};
  assign hpos = !hx[XW-1] && (hx != '0);

  always_comb begin
    hsec = 2'd0;
    unique case (1'b1)
      hpos && hbig:   hsec = 2'd3;
      hpos && !hbig:  hsec = 2'd2;
      !hpos && !hbig: hsec = 2'd1;
      !hpos && hbig:  hsec = 2'd0;
    endcase
  end

  logic [AW-1:0] base, a_top, a_nm, a_rc, a_ck;
  assign base  = AW'({ch_q, sec_q} * NK);
  assign a_top = base + AW'(ORDER);
  assign a_nm  = base + AW'(ORDER + 1);
  assign a_rc  = base + AW'(ORDER + 2);
  assign a_ck  = base + AW'(k_q);

  logic signed [PW-1:0] xw, nsum, nprod, mprod, msum;
  logic signed [CW-1:0] t_norm, acc_mac;
  logic signed [XW-1:0] x_out;

  always_comb begin
    xw      = {{(PW-XW){x_q[XW-1]}}, x_q};
    nsum    = (xw <<< CFRAC) + sx(bank_q[a_nm]);
    nprod   = nsum * sx(bank_q[a_rc]);
    t_norm  = sat_cw(nprod >>> CFRAC);
    mprod   = sx(acc_q) * sx(t_q);
    msum    = (mprod >>> CFRAC) + sx(bank_q[a_ck]);
    acc_mac = sat_cw(msum);
    x_out   = sat_xw(sx(acc_mac) >>> CFRAC);
  end

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    x_d      = x_q;
    ch_d     = ch_q;
    sec_d    = sec_q;
    t_d      = t_q;
    acc_d    = acc_q;
    x_lin_d  = x_lin_q;
    ch_out_d = ch_out_q;
    srdyo_d  = srdyo_q;
    unique case (state_q)
      S_IDLE: begin
        if (!empty) begin
          x_d     = hx;
          ch_d    = hch;
          sec_d   = hsec;
          state_d = S_NORM;
        end
      end
      S_NORM: begin
        t_d     = t_norm;
        acc_d   = bank_q[a_top];
        k_d     = KW'(ORDER - 1);
        state_d = S_MAC;
      end
      S_MAC: begin
        acc_d = acc_mac;
        if (k_q == '0) begin
          x_lin_d  = x_out;
          ch_out_d = ch_q;
          srdyo_d  = 1'b1;
          state_d  = S_OUT;
        end else begin
          k_d = k_q - 1'b1;
        end
      end
      default: begin
        if (s.drdyo) begin
          srdyo_d = 1'b0;
          state_d = S_IDLE;
        end
      end
    endcase
  end

  always_comb begin
    mem_d = mem_q;
    wp_d  = wp_q;
    rp_d  = rp_q;
    cnt_d = cnt_q;
    if (push) begin
      mem_d[wp_q] = {s.ch_in, s.x_adc};
      wp_d        = wp_q + 1'b1;
    end
    if (pop) rp_d = rp_q + 1'b1;
    if (push && !pop) cnt_d = cnt_q + 1'b1;
    if (!push && pop) cnt_d = cnt_q - 1'b1;
  end

  // Bank is frozen whenever a sample is queued or in flight
  assign cfg_ok = cfg_we && !busy &&
                  ({1'b0, cfg_addr} < (AW+1)'(NENT));

  always_comb begin
    bank_d    = bank_q;
    cfg_err_d = cfg_we && !cfg_ok;
    if (cfg_ok) bank_d[cfg_addr] = cfg_wdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      k_q       <= '0;
      x_q       <= '0;
      ch_q      <= '0;
      sec_q     <= '0;
      t_q       <= '0;
      acc_q     <= '0;
      x_lin_q   <= '0;
      ch_out_q  <= '0;
      srdyo_q   <= 1'b0;
      cfg_err_q <= 1'b0;
      wp_q      <= '0;
      rp_q      <= '0;
      cnt_q     <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      for (int i = 0; i < NENT; i++) bank_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      x_q       <= x_d;
      ch_q      <= ch_d;
      sec_q     <= sec_d;
      t_q       <= t_d;
      acc_q     <= acc_d;
      x_lin_q   <= x_lin_d;
      ch_out_q  <= ch_out_d;
      srdyo_q   <= srdyo_d;
      cfg_err_q <= cfg_err_d;
      wp_q      <= wp_d;
      rp_q      <= rp_d;
      cnt_q     <= cnt_d;
      mem_q     <= mem_d;
      bank_q    <= bank_d;
    end
  end

  assign s.drdyi  = !full;
  assign s.srdyo  = srdyo_q;
  assign s.x_lin  = x_lin_q;
  assign s.ch_out = ch_out_q;
  assign cfg_err  = cfg_err_q;
endmodule

// File: tb/tb_nlc_horner_mc.sv
// Directed bench for nlc_horner_mc: stimulus pushes expected outputs into
// a queue, a negedge monitor pops and compares on every srdyo&drdyo.
module tb_nlc_horner_mc;
  localparam logic [47:0] ONE  = 48'h000001000000;
  localparam logic [47:0] PMAX = 48'h7FFFFFFFFFFF;
  localparam logic [47:0] PMIN = 48'h800000000000;
  localparam logic [47:0] BIG  = 48'h7FFFFF000000;

  typedef struct {
    logic signed [20:0] x;
    logic [1:0]         ch;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [19:0] section_limit = 20'd1000;
  logic        cfg_we = 1'b0;
  logic [7:0]  cfg_addr = '0;
  logic [47:0] cfg_wdata = '0;
  logic        cfg_err;
  logic        busy;
  int          checks = 0;
  int          errors = 0;
  exp_t        exp_q [$];

  nlc_horner_mc_if #(.XW(21), .CHW(2)) bus ();

  nlc_horner_mc dut (
    .clk           (clk),
    .reset         (rst_n),
    .s             (bus),
    .section_limit (section_limit),
    .cfg_we        (cfg_we),
    .cfg_addr      (cfg_addr),
    .cfg_wdata     (cfg_wdata),
    .cfg_err       (cfg_err),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n && bus.srdyo && bus.drdyo) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_out x_lin=%0d ch=%0d",
                 bus.x_lin, bus.ch_out);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (bus.x_lin !== e.x || bus.ch_out !== e.ch) begin
          errors++;
          $display("FAIL out got x=%0d ch=%0d want x=%0d ch=%0d",
                   bus.x_lin, bus.ch_out, e.x, e.ch);
        end
      end
    end
  end

  task automatic chk(input string nm, input longint act,
                     input longint want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", nm, act, want);
    end
  endtask

  function automatic logic [7:0] A(input int ch, input int sec,
                                   input int k);
    return 8'((ch * 4 + sec) * 13 + k);
  endfunction

  task automatic cfg_wr(input logic [7:0] a, input logic [47:0] d);
    cfg_we    = 1'b1;
    cfg_addr  = a;
    cfg_wdata = d;
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  task automatic push(input int x, input int ch, input int ex,
                      input bit keep);
    int w = 0;
    while (!bus.drdyi && w < 100) begin
      @(posedge clk); #1;
      w++;
    end
    if (!bus.drdyi) begin
      checks++;
      errors++;
      $display("FAIL push_timeout drdyi=0 want=1");
    end
    if (keep) exp_q.push_back('{x: 21'(ex), ch: 2'(ch)});
    bus.srdyi = 1'b1;
    bus.x_adc = 21'(x);
    bus.ch_in = 2'(ch);
    @(posedge clk); #1;
    bus.srdyi = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int w = 0;
    while ((busy || exp_q.size() != 0) && w < 500) begin
      @(posedge clk); #1;
      w++;
    end
    chk({nm, "_drain"}, longint'(busy || exp_q.size() != 0), 0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic prog_identity();
    for (int s = 0; s < 4; s++) begin
      cfg_wr(A(0, s, 1), ONE);
      cfg_wr(A(0, s, 12), ONE);
    end
  endtask

  initial begin
    int n;
    bus.srdyi = 1'b0;
    bus.x_adc = '0;
    bus.ch_in = '0;
    bus.drdyo = 1'b1;
    #12;
    chk("rst_srdyo", bus.srdyo, 0);
    chk("rst_xlin", bus.x_lin, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cfgerr", cfg_err, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("rst_drdyi", bus.drdyi, 1);

    prog_identity();
    push(100, 0, 100, 1);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!bus.srdyo && n < 40);
    chk("latency", n, 12);
    push(-100, 0, -100, 1);
    wait_idle("identity");

    do_reset();
    for (int s = 0; s < 4; s++) cfg_wr(A(0, s, 0), ONE * (s + 1));
    push(-1001, 0, 1, 1);
    push(-1000, 0, 2, 1);
    push(0, 0, 2, 1);
    push(1000, 0, 3, 1);
    push(1001, 0, 4, 1);
    wait_idle("sections");

    do_reset();
    cfg_wr(A(0, 1, 0), PMAX);
    push(0, 0, 1048575, 1);
    wait_idle("satpos");
    cfg_wr(A(0, 1, 0), PMIN);
    push(0, 0, -1048576, 1);
    wait_idle("satneg");
    cfg_wr(A(0, 3, 10), BIG);
    cfg_wr(A(0, 3, 9), BIG);
    cfg_wr(A(0, 3, 12), ONE);
    push(1000000, 0, 1048575, 1);
    wait_idle("macsat");

    do_reset();
    cfg_wr(A(2, 2, 11), -(ONE * 50));
    cfg_wr(A(2, 2, 12), ONE >> 1);
    cfg_wr(A(2, 2, 1), ONE);
    push(150, 2, 50, 1);
    push(150, 0, 0, 1);
    wait_idle("norm");

    do_reset();
    prog_identity();
    bus.drdyo = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bus.srdyi = 1'b1;
      bus.x_adc = 21'(11 + i);
      bus.ch_in = 2'd0;
      if (i < 5) exp_q.push_back('{x: 21'(11 + i), ch: 2'd0});
      else chk("bp_drdyi_full", bus.drdyi, 0);
      @(posedge clk); #1;
    end
    bus.srdyi = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("bp_srdyo_held", bus.srdyo, 1);
    chk("bp_xlin_held", bus.x_lin, 11);
    chk("bp_still_full", bus.drdyi, 0);
    bus.drdyo = 1'b1;
    wait_idle("bp");
    chk("bp_drdyi_back", bus.drdyi, 1);

    push(7, 0, 7, 1);
    cfg_wr(A(0, 2, 1), ONE * 2);
    chk("lock_err", cfg_err, 1);
    @(posedge clk); #1;
    chk("lock_err_pulse", cfg_err, 0);
    wait_idle("lock1");
    push(7, 0, 7, 1);
    wait_idle("lock2");
    cfg_wr(8'd208, ONE);
    chk("range_err", cfg_err, 1);
    cfg_wr(A(0, 2, 0), '0);
    chk("ok_noerr", cfg_err, 0);

    push(5, 0, 0, 0);
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_srdyo", bus.srdyo, 0);
    chk("midrst_xlin", bus.x_lin, 0);
    chk("midrst_busy", busy, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    chk("postrst_srdyo", bus.srdyo, 0);
    chk("postrst_busy", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
